// File: rtl/byte_frame_parser.sv
// Frame parser behind the CDC byte register: sync byte, payload, XOR checksum.
// Emits each good payload as one wide word and flags checksum and timeout errors.
module byte_frame_parser #(
    parameter int              SIZE           = 8,
    parameter int              PAYLOAD_BYTES  = 4,
    parameter logic [SIZE-1:0] SYNC_BYTE      = 8'hA5,
    parameter int              TIMEOUT_CYCLES = 50000
) (
    input  logic                          r_clk,
    input  logic                          rst,
    input  logic [SIZE-1:0]               in_data,
    input  logic                          in_empty,
    output logic [SIZE*PAYLOAD_BYTES-1:0] frame_data,
    output logic                          frame_valid,
    output logic                          chk_err,
    output logic                          timeout_err,
    output logic                          busy,
    output logic [7:0]                    good_cnt,
    output logic [1:0]                    dbg_state
);

    localparam int PW    = SIZE * PAYLOAD_BYTES;
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int IDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    // The counter value seen at the edge where it would step to TIMEOUT_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_CHECK   = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_empty_q;
    logic [CNT_W-1:0] r_cnt;
    logic [SIZE-1:0]  r_acc;
    logic [IDX_W-1:0] r_idx;
    logic [PW-1:0]    r_payload;
    logic             w_byte_stb;
    logic             w_expired;

    // One strobe per falling edge of in_empty, however long it stays low.
    assign w_byte_stb = r_empty_q & ~in_empty;
    assign w_expired  = ~w_byte_stb && (r_cnt == CNT_LAST);
    assign dbg_state  = r_state;

    always_ff @(posedge r_clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_empty_q   <= 1'b1;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_idx       <= '0;
            r_payload   <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            chk_err     <= 1'b0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
            good_cnt    <= 8'd0;
        end else begin
            r_empty_q   <= in_empty;
            frame_valid <= 1'b0;
            chk_err     <= 1'b0;
            timeout_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_byte_stb && (in_data == SYNC_BYTE)) begin
                        r_state <= S_PAYLOAD;
                        r_idx   <= '0;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                    end
                end
                S_PAYLOAD: begin
                    if (w_byte_stb) begin
                        r_payload <= PW'({r_payload, in_data});
                        r_acc     <= r_acc ^ in_data;
                        r_cnt     <= '0;
                        if (r_idx == IDX_LAST) begin
                            r_idx   <= '0;
                            r_state <= S_CHECK;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end else if (w_expired) begin
                        timeout_err <= 1'b1;
                        r_state     <= S_IDLE;
                        r_cnt       <= '0;
                        busy        <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_CHECK: begin
                    if (w_byte_stb) begin
                        if (in_data == r_acc) begin
                            frame_data  <= r_payload;
                            frame_valid <= 1'b1;
                            good_cnt    <= good_cnt + 8'd1;
                        end else begin
                            chk_err <= 1'b1;
                        end
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        busy    <= 1'b0;
                    end else if (w_expired) begin
                        timeout_err <= 1'b1;
                        r_state     <= S_IDLE;
                        r_cnt       <= '0;
                        busy        <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_frame_parser.sv
// Bench for byte_frame_parser: directed scenarios plus random frame streams
// scored against a stream-level frame model.
module tb_byte_frame_parser;

    localparam int         PB   = 4;
    localparam int         TO   = 100;
    localparam logic [7:0] SYNC = 8'hA5;

    logic        r_clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_empty = 1'b1;
    logic [31:0] frame_data;
    logic        frame_valid, chk_err, timeout_err, busy;
    logic [7:0]  good_cnt;
    logic [1:0]  dbg_state;

    byte_frame_parser #(.SIZE(8), .PAYLOAD_BYTES(PB), .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TO)) dut (
        .r_clk(r_clk), .rst(rst), .in_data(in_data), .in_empty(in_empty),
        .frame_data(frame_data), .frame_valid(frame_valid), .chk_err(chk_err),
        .timeout_err(timeout_err), .busy(busy), .good_cnt(good_cnt), .dbg_state(dbg_state)
    );

    // clock / reset block
    always #5 r_clk = ~r_clk;
    int cyc = 0;
    always @(posedge r_clk) cyc <= cyc + 1;

    // events: kind 1 = frame_valid+data, 2 = chk_err, 3 = timeout_err, 0 = overlapping pulses
    logic [33:0] exp_q[$];
    int          exp_t[$];
    logic [33:0] obs_q[$];
    int          obs_t[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          exp_good = 0;
    logic [31:0] exp_fd = 32'h0;
    int          last_stb = 0;

    always @(negedge r_clk) begin
        if (frame_valid || chk_err || timeout_err) begin
            if ((int'(frame_valid) + int'(chk_err) + int'(timeout_err)) > 1) obs_q.push_back({2'd0, 32'h0});
            else if (frame_valid) obs_q.push_back({2'd1, frame_data});
            else if (chk_err)     obs_q.push_back({2'd2, 32'h0});
            else                  obs_q.push_back({2'd3, 32'h0});
            obs_t.push_back(cyc);
        end
    end

    // driver tasks
    task automatic send_byte(input logic [7:0] b, input int lo, input int hi);
        in_data  = b;
        in_empty = 1'b0;
        last_stb = cyc + 1;
        repeat (lo) @(negedge r_clk);
        in_empty = 1'b1;
        repeat (hi) @(negedge r_clk);
    endtask

    task automatic send_frame(input logic [31:0] pl, input logic [7:0] ck, input int lo, input int hi);
        send_byte(SYNC, lo, hi);
        for (int i = 3; i >= 0; i--) send_byte(pl[i*8 +: 8], lo, hi);
        send_byte(ck, lo, hi);
    endtask

    function automatic logic [7:0] xsum(input logic [31:0] pl);
        return pl[31:24] ^ pl[23:16] ^ pl[15:8] ^ pl[7:0];
    endfunction

    // reference model over a whole byte stream
    function automatic void model_stream(input logic [7:0] s[$], input int t[$]);
        int i = 0;
        logic [31:0] pl;
        logic [7:0]  acc;
        while (i < s.size()) begin
            if (s[i] == SYNC && i + PB + 1 < s.size()) begin
                pl = 32'h0; acc = 8'h0;
                for (int j = 1; j <= PB; j++) begin
                    pl  = (pl << 8) | 32'(s[i+j]);
                    acc = acc ^ s[i+j];
                end
                if (s[i+PB+1] == acc) begin
                    exp_q.push_back({2'd1, pl});
                    exp_good = (exp_good + 1) % 256;
                    exp_fd   = pl;
                end else begin
                    exp_q.push_back({2'd2, 32'h0});
                end
                exp_t.push_back(t[i+PB+1]);
                i = i + PB + 2;
            end else begin
                i = i + 1;
            end
        end
    endfunction

    task automatic test_reset;
        n_chk++; if (frame_data !== 32'h0) $display("FAIL rst_frame_data: got %h exp 0", frame_data); else n_pass++;
        n_chk++; if (frame_valid !== 1'b0) $display("FAIL rst_frame_valid: got %b exp 0", frame_valid); else n_pass++;
        n_chk++; if (chk_err !== 1'b0) $display("FAIL rst_chk_err: got %b exp 0", chk_err); else n_pass++;
        n_chk++; if (timeout_err !== 1'b0) $display("FAIL rst_timeout_err: got %b exp 0", timeout_err); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b exp 0", busy); else n_pass++;
        n_chk++; if (good_cnt !== 8'd0) $display("FAIL rst_good_cnt: got %0d exp 0", good_cnt); else n_pass++;
        n_chk++; if (dbg_state !== 2'd0) $display("FAIL rst_state: got %0d exp 0", dbg_state); else n_pass++;
    endtask

    task automatic test_good_frame;
        logic [33:0] g, e; int gt, et;
        send_byte(SYNC, 20, 20);
        n_chk++; if (busy !== 1'b1) $display("FAIL good_busy: got %b exp 1", busy); else n_pass++;
        send_byte(8'h11, 20, 20); send_byte(8'h22, 20, 20); send_byte(8'h33, 20, 20); send_byte(8'h44, 20, 20);
        send_byte(8'h44, 20, 20);
        exp_q.push_back({2'd1, 32'h11223344}); exp_t.push_back(last_stb);
        exp_good = 1; exp_fd = 32'h11223344;
        repeat (3) @(negedge r_clk);
        while (exp_q.size() + obs_q.size() > 0) begin
            e = exp_q.size() > 0 ? exp_q.pop_front() : '1; et = exp_t.size() > 0 ? exp_t.pop_front() : -1;
            g = obs_q.size() > 0 ? obs_q.pop_front() : '1; gt = obs_t.size() > 0 ? obs_t.pop_front() : -1;
            n_chk++;
            if (g !== e || gt != et) $display("FAIL good_event: got %h@%0d exp %h@%0d", g, gt, e, et); else n_pass++;
        end
        n_chk++; if (frame_data !== 32'h11223344) $display("FAIL good_data: got %h exp 11223344", frame_data); else n_pass++;
        n_chk++; if (good_cnt !== 8'd1) $display("FAIL good_cnt: got %0d exp 1", good_cnt); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL good_busy_after: got %b exp 0", busy); else n_pass++;
    endtask

    task automatic test_bad_checksum;
        logic [33:0] g, e; int gt, et;
        send_frame(32'h11223344, 8'h45, 20, 20);
        exp_q.push_back({2'd2, 32'h0}); exp_t.push_back(last_stb);
        repeat (3) @(negedge r_clk);
        while (exp_q.size() + obs_q.size() > 0) begin
            e = exp_q.size() > 0 ? exp_q.pop_front() : '1; et = exp_t.size() > 0 ? exp_t.pop_front() : -1;
            g = obs_q.size() > 0 ? obs_q.pop_front() : '1; gt = obs_t.size() > 0 ? obs_t.pop_front() : -1;
            n_chk++;
            if (g !== e || gt != et) $display("FAIL bad_event: got %h@%0d exp %h@%0d", g, gt, e, et); else n_pass++;
        end
        n_chk++; if (frame_data !== exp_fd) $display("FAIL bad_data_held: got %h exp %h", frame_data, exp_fd); else n_pass++;
        n_chk++; if (good_cnt !== 8'(exp_good)) $display("FAIL bad_cnt: got %0d exp %0d", good_cnt, exp_good); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL bad_busy: got %b exp 0", busy); else n_pass++;
    endtask

    task automatic test_garbage;
        logic [33:0] g, e; int gt, et;
        send_byte(8'h00, 20, 20); send_byte(8'hFF, 20, 20); send_byte(8'h5A, 20, 20);
        n_chk++; if (busy !== 1'b0) $display("FAIL garbage_idle: got busy %b exp 0", busy); else n_pass++;
        send_frame(32'hA5010203, 8'hA5, 20, 20);
        exp_q.push_back({2'd1, 32'hA5010203}); exp_t.push_back(last_stb);
        exp_good = exp_good + 1; exp_fd = 32'hA5010203;
        repeat (3) @(negedge r_clk);
        while (exp_q.size() + obs_q.size() > 0) begin
            e = exp_q.size() > 0 ? exp_q.pop_front() : '1; et = exp_t.size() > 0 ? exp_t.pop_front() : -1;
            g = obs_q.size() > 0 ? obs_q.pop_front() : '1; gt = obs_t.size() > 0 ? obs_t.pop_front() : -1;
            n_chk++;
            if (g !== e || gt != et) $display("FAIL garbage_event: got %h@%0d exp %h@%0d", g, gt, e, et); else n_pass++;
        end
        n_chk++; if (good_cnt !== 8'(exp_good)) $display("FAIL garbage_cnt: got %0d exp %0d", good_cnt, exp_good); else n_pass++;
    endtask

    task automatic test_timeout;
        logic [33:0] g, e; int gt, et;
        send_byte(SYNC, 20, 20);
        send_byte(8'h11, 20, 130);
        exp_q.push_back({2'd3, 32'h0}); exp_t.push_back(last_stb + TO - 1);
        n_chk++; if (busy !== 1'b0) $display("FAIL to_busy: got %b exp 0", busy); else n_pass++;
        send_frame(32'h11223344, 8'h44, 20, 20);
        exp_q.push_back({2'd1, 32'h11223344}); exp_t.push_back(last_stb);
        exp_good = exp_good + 1; exp_fd = 32'h11223344;
        repeat (3) @(negedge r_clk);
        while (exp_q.size() + obs_q.size() > 0) begin
            e = exp_q.size() > 0 ? exp_q.pop_front() : '1; et = exp_t.size() > 0 ? exp_t.pop_front() : -1;
            g = obs_q.size() > 0 ? obs_q.pop_front() : '1; gt = obs_t.size() > 0 ? obs_t.pop_front() : -1;
            n_chk++;
            if (g !== e || gt != et) $display("FAIL to_event: got %h@%0d exp %h@%0d", g, gt, e, et); else n_pass++;
        end
        n_chk++; if (good_cnt !== 8'(exp_good)) $display("FAIL to_cnt: got %0d exp %0d", good_cnt, exp_good); else n_pass++;
    endtask

    task automatic test_timeout_boundary;
        logic [33:0] g, e; int gt, et;
        send_byte(SYNC, 20, 20);
        // next strobe lands TO-1 cycles after this one: the expiry cycle
        send_byte(8'h11, 20, TO - 21);
        send_byte(8'h22, 20, 20); send_byte(8'h33, 20, 20); send_byte(8'h44, 20, 20);
        send_byte(8'h44, 20, 20);
        exp_q.push_back({2'd1, 32'h11223344}); exp_t.push_back(last_stb);
        exp_good = exp_good + 1; exp_fd = 32'h11223344;
        repeat (3) @(negedge r_clk);
        while (exp_q.size() + obs_q.size() > 0) begin
            e = exp_q.size() > 0 ? exp_q.pop_front() : '1; et = exp_t.size() > 0 ? exp_t.pop_front() : -1;
            g = obs_q.size() > 0 ? obs_q.pop_front() : '1; gt = obs_t.size() > 0 ? obs_t.pop_front() : -1;
            n_chk++;
            if (g !== e || gt != et) $display("FAIL bnd_event: got %h@%0d exp %h@%0d", g, gt, e, et); else n_pass++;
        end
        n_chk++; if (good_cnt !== 8'(exp_good)) $display("FAIL bnd_cnt: got %0d exp %0d", good_cnt, exp_good); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [33:0] g, e; int gt, et;
        logic [7:0] s[$]; int t[$];
        logic [31:0] pl;
        for (int f = 0; f < 3; f++) begin
            pl = $urandom;
            send_byte(SYNC, 1, 1); s.push_back(SYNC); t.push_back(last_stb);
            for (int i = 3; i >= 0; i--) begin
                send_byte(pl[i*8 +: 8], 1, 1); s.push_back(pl[i*8 +: 8]); t.push_back(last_stb);
            end
            send_byte(xsum(pl), 1, 1); s.push_back(xsum(pl)); t.push_back(last_stb);
        end
        model_stream(s, t);
        repeat (3) @(negedge r_clk);
        while (exp_q.size() + obs_q.size() > 0) begin
            e = exp_q.size() > 0 ? exp_q.pop_front() : '1; et = exp_t.size() > 0 ? exp_t.pop_front() : -1;
            g = obs_q.size() > 0 ? obs_q.pop_front() : '1; gt = obs_t.size() > 0 ? obs_t.pop_front() : -1;
            n_chk++;
            if (g !== e || gt != et) $display("FAIL b2b_event: got %h@%0d exp %h@%0d", g, gt, e, et); else n_pass++;
        end
        n_chk++; if (good_cnt !== 8'(exp_good)) $display("FAIL b2b_cnt: got %0d exp %0d", good_cnt, exp_good); else n_pass++;
    endtask

    task automatic test_random;
        logic [33:0] g, e; int gt, et;
        logic [7:0] s[$]; int t[$];
        logic [7:0] b;
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                b = 8'($urandom);
                if (b == SYNC) b = 8'h00;
            end else if ((n % 6) == 0 || $urandom_range(0, 3) == 0) begin
                b = 8'($urandom);
            end else begin
                b = (s.size() > 0 && $urandom_range(0, 4) == 0) ? SYNC : 8'($urandom);
            end
            if ((n % 12) == 0) b = SYNC;
            send_byte(b, $urandom_range(1, 4), $urandom_range(1, 4));
            s.push_back(b); t.push_back(last_stb);
        end
        // pad so the last frame can always complete in the DUT and the model alike
        for (int n = 0; n < PB + 2; n++) begin
            send_byte(8'h00, 1, 1); s.push_back(8'h00); t.push_back(last_stb);
        end
        model_stream(s, t);
        repeat (3) @(negedge r_clk);
        while (exp_q.size() + obs_q.size() > 0) begin
            e = exp_q.size() > 0 ? exp_q.pop_front() : '1; et = exp_t.size() > 0 ? exp_t.pop_front() : -1;
            g = obs_q.size() > 0 ? obs_q.pop_front() : '1; gt = obs_t.size() > 0 ? obs_t.pop_front() : -1;
            n_chk++;
            if (g !== e || gt != et) $display("FAIL rand_event: got %h@%0d exp %h@%0d", g, gt, e, et); else n_pass++;
        end
        n_chk++; if (frame_data !== exp_fd) $display("FAIL rand_data: got %h exp %h", frame_data, exp_fd); else n_pass++;
        n_chk++; if (good_cnt !== 8'(exp_good)) $display("FAIL rand_cnt: got %0d exp %0d", good_cnt, exp_good); else n_pass++;
    endtask

    task automatic test_cnt_wrap;
        logic [33:0] g, e; int gt, et;
        logic [31:0] pl;
        do begin
            pl = $urandom;
            send_frame(pl, xsum(pl), 1, 1);
            exp_q.push_back({2'd1, pl}); exp_t.push_back(last_stb);
            exp_good = (exp_good + 1) % 256; exp_fd = pl;
        end while (exp_good != 0);
        repeat (3) @(negedge r_clk);
        while (exp_q.size() + obs_q.size() > 0) begin
            e = exp_q.size() > 0 ? exp_q.pop_front() : '1; et = exp_t.size() > 0 ? exp_t.pop_front() : -1;
            g = obs_q.size() > 0 ? obs_q.pop_front() : '1; gt = obs_t.size() > 0 ? obs_t.pop_front() : -1;
            n_chk++;
            if (g !== e || gt != et) $display("FAIL wrap_event: got %h@%0d exp %h@%0d", g, gt, e, et); else n_pass++;
        end
        n_chk++; if (good_cnt !== 8'd0) $display("FAIL wrap_cnt: got %0d exp 0", good_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid_frame;
        logic [33:0] g, e; int gt, et;
        send_byte(SYNC, 20, 20); send_byte(8'h11, 20, 20); send_byte(8'h22, 20, 20);
        rst = 1'b0;
        repeat (3) @(negedge r_clk);
        exp_good = 0; exp_fd = 32'h0;
        n_chk++; if (frame_data !== 32'h0) $display("FAIL mid_frame_data: got %h exp 0", frame_data); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b exp 0", busy); else n_pass++;
        n_chk++; if (good_cnt !== 8'd0) $display("FAIL mid_cnt: got %0d exp 0", good_cnt); else n_pass++;
        n_chk++; if ({frame_valid, chk_err, timeout_err} !== 3'b000) $display("FAIL mid_pulses: got %b exp 000", {frame_valid, chk_err, timeout_err}); else n_pass++;
        n_chk++; if (obs_q.size() != 0) $display("FAIL mid_no_event: got %0d events exp 0", obs_q.size()); else n_pass++;
        rst = 1'b1;
        repeat (2) @(negedge r_clk);
        send_frame(32'h11223344, 8'h44, 20, 20);
        exp_q.push_back({2'd1, 32'h11223344}); exp_t.push_back(last_stb);
        exp_good = 1; exp_fd = 32'h11223344;
        repeat (3) @(negedge r_clk);
        while (exp_q.size() + obs_q.size() > 0) begin
            e = exp_q.size() > 0 ? exp_q.pop_front() : '1; et = exp_t.size() > 0 ? exp_t.pop_front() : -1;
            g = obs_q.size() > 0 ? obs_q.pop_front() : '1; gt = obs_t.size() > 0 ? obs_t.pop_front() : -1;
            n_chk++;
            if (g !== e || gt != et) $display("FAIL mid_event: got %h@%0d exp %h@%0d", g, gt, e, et); else n_pass++;
        end
        n_chk++; if (good_cnt !== 8'd1) $display("FAIL mid_cnt_after: got %0d exp 1", good_cnt); else n_pass++;
    endtask

    initial begin
        rst = 1'b0;
        in_empty = 1'b1;
        repeat (3) @(negedge r_clk);
        test_reset;
        rst = 1'b1;
        repeat (2) @(negedge r_clk);
        test_good_frame;
        test_bad_checksum;
        test_garbage;
        test_timeout;
        test_timeout_boundary;
        test_back_to_back;
        test_random;
        test_cnt_wrap;
        test_reset_mid_frame;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
